test_harness_ctrl: RTL and testbench

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

---
 rtl/test_harness_pkg.sv | 21 ++
 rtl/harness_edge_detect.sv | 20 ++
 rtl/test_harness_ctrl.sv | 146 ++++++++++++++
 tb/tb_test_harness_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_harness_pkg.sv
// Shared definitions for the CPU test-harness controller: FSM state encodings
// and the default values of the controller parameters.
package test_harness_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LED_W        = 8;
  localparam int DEF_DONE_BIT     = 0;
  localparam int DEF_RESET_CYCLES = 10;
  localparam int DEF_TIMEOUT      = 1000000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_HOLD   = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_DUMP   = 3'd4;
  localparam state_t ST_FINISH = 3'd5;

endpackage

// File: rtl/harness_edge_detect.sv
// Rising-edge detector for the CPU completion LED. The history register follows
// the level every cycle, so a level already high when arm rises is not an edge.
module harness_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_arm,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_level;
  end

  assign o_rise = i_arm & i_level & ~r_prev;

endmodule

// File: rtl/test_harness_ctrl.sv
// Test-harness controller: streams a program into data memory, holds the CPU in
// reset, runs it until the done LED rises or a timeout, then dumps the memory.
module test_harness_ctrl
  import test_harness_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LED_W        = DEF_LED_W,
  parameter int DONE_BIT     = DEF_DONE_BIT,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_mem_own,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_cpu_reset,
  input  logic [LED_W-1:0]  i_leds,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  input  logic              i_dump_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timed_out,
  output logic [31:0]       o_run_cycles
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_hold_cnt;
  logic [31:0]         r_run_cycles;
  logic                r_timed_out;
  logic                r_rd_pend;
  logic                r_dump_valid;
  logic [DATA_W-1:0]   r_dump_data;

  logic                w_rise;
  logic                w_we;
  logic                w_timeout;
  logic [31:0]         w_run_next;
  logic                w_unused_leds;

  harness_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_arm   (r_state == ST_RUN),
    .i_level (i_leds[DONE_BIT]),
    .o_rise  (w_rise)
  );

  assign w_unused_leds = ^i_leds;
  assign w_we          = (r_state == ST_LOAD) && i_load_valid;
  assign w_run_next    = (&r_run_cycles) ? r_run_cycles : r_run_cycles + 32'd1;
  assign w_timeout     = (TIMEOUT != 0) && (w_run_next >= 32'(TIMEOUT));

  // Dump reads take two phases: present the address, then capture the data
  // the memory returns one cycle later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_hold_cnt   <= '0;
      r_run_cycles <= '0;
      r_timed_out  <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          if (i_start) begin
            r_state      <= ST_LOAD;
            r_addr       <= '0;
            r_run_cycles <= '0;
            r_timed_out  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_load_valid) begin
            if (i_load_last || (&r_addr)) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == 32'(RESET_CYCLES - 1)) r_state <= ST_RUN;
          else                                     r_hold_cnt <= r_hold_cnt + 32'd1;
        end
        ST_RUN: begin
          r_run_cycles <= w_run_next;
          if (w_rise || w_timeout) begin
            r_state      <= ST_DUMP;
            r_timed_out  <= ~w_rise;
            r_addr       <= '0;
            r_rd_pend    <= 1'b0;
            r_dump_valid <= 1'b0;
          end
        end
        ST_DUMP: begin
          if (r_dump_valid) begin
            if (i_dump_ready) begin
              r_dump_valid <= 1'b0;
              if (&r_addr) r_state <= ST_FINISH;
              else         r_addr  <= r_addr + 1'b1;
            end
          end else if (r_rd_pend) begin
            r_dump_data  <= i_mem_rdata;
            r_dump_valid <= 1'b1;
            r_rd_pend    <= 1'b0;
          end else begin
            r_rd_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_load_ready = (r_state == ST_LOAD);
  assign o_mem_own    = (r_state != ST_RUN);
  assign o_cpu_reset  = (r_state != ST_RUN);
  assign o_mem_addr   = r_addr;
  assign o_mem_we     = w_we;
  assign o_mem_wdata  = w_we ? i_load_data : '0;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_addr  = r_addr;
  assign o_dump_data  = r_dump_data;
  assign o_busy       = (r_state == ST_LOAD) || (r_state == ST_HOLD) ||
                        (r_state == ST_RUN)  || (r_state == ST_DUMP);
  assign o_done       = (r_state == ST_FINISH);
  assign o_timed_out  = r_timed_out;
  assign o_run_cycles = r_run_cycles;

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Self-checking bench for test_harness_ctrl with an 8-word memory model; a run
// limit of 60 cycles keeps the timeout scenario clear of the 50-cycle LED scenario.
module tb_test_harness_ctrl;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 32;
  localparam int LED_W     = 8;
  localparam int TIMEOUT_P = 60;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        expReady;
    logic        expWe;
    logic [2:0]  expAddr;
  } loadVec_t;

  logic              clk = 1'b0;
  logic              reset, start, loadValid, loadLast, loadReady;
  logic [DATA_W-1:0] loadData, memWdata, dumpData;
  logic              memOwn, memWe, cpuReset, dumpValid, dumpReady;
  logic [ADDR_W-1:0] memAddr, dumpAddr;
  logic [DATA_W-1:0] memRdata;
  logic [LED_W-1:0]  ledBus;
  logic              busy, done, timedOut;
  logic [31:0]       runCycles;
  logic              memPreload;

  logic [31:0] memModel [8];
  logic [31:0] expMem   [8];
  loadVec_t    vecA [4];
  loadVec_t    vecB [9];
  loadVec_t    vecC [2];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  test_harness_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LED_W(LED_W), .DONE_BIT(0),
    .RESET_CYCLES(10), .TIMEOUT(TIMEOUT_P)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_load_valid(loadValid), .i_load_data(loadData), .i_load_last(loadLast),
    .o_load_ready(loadReady), .o_mem_own(memOwn), .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata), .o_mem_we(memWe), .i_mem_rdata(memRdata),
    .o_cpu_reset(cpuReset), .i_leds(ledBus), .o_dump_valid(dumpValid),
    .o_dump_addr(dumpAddr), .o_dump_data(dumpData), .i_dump_ready(dumpReady),
    .o_busy(busy), .o_done(done), .o_timed_out(timedOut), .o_run_cycles(runCycles)
  );

  // Synchronous-read data memory shared by the controller (and, notionally, the CPU).
  always @(posedge clk) begin
    if (memPreload) begin
      for (int i = 0; i < 8; i++) memModel[i] <= 32'hC0DE_0000 + i;
    end else if (memWe) begin
      memModel[memAddr] <= memWdata;
    end
    memRdata <= memModel[memAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input loadVec_t v, input string tag);
    @(negedge clk);
    loadValid = v.valid;
    loadData  = v.data;
    loadLast  = v.last;
    #1;
    checkOutput({tag, "Ready"}, loadReady, v.expReady);
    checkOutput({tag, "We"}, memWe, v.expWe);
    if (v.expWe) begin
      checkOutput({tag, "Addr"}, memAddr, v.expAddr);
      checkOutput({tag, "Wdata"}, memWdata, v.data);
    end
    @(posedge clk);
    if (v.expWe) expMem[v.expAddr] = v.data;
    #1;
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitRunEntry();
    for (int c = 0; c < 100 && cpuReset; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("runEntry", cpuReset, 1'b0);
  endtask

  // Called one step after the DUMP entry edge; collects the 8 words in order.
  task automatic dumpAll(input int stallAddr, input int stallLen);
    int   edges = 0;
    int   words = 0;
    int   stallLeft;
    logic seen;
    logic sawValid;
    stallLeft = stallLen;
    seen      = 1'b0;
    dumpReady = 1'b1;
    for (int cyc = 0; cyc < 300 && words < 8; cyc++) begin
      @(negedge clk);
      sawValid = dumpValid;
      if (sawValid) begin
        if (!seen) checkOutput("dumpLatency", edges, 2);
        seen = 1'b1;
        checkOutput("dumpAddr", dumpAddr, words);
        checkOutput("dumpData", dumpData, expMem[words]);
        if (words == stallAddr && stallLeft > 0) begin
          dumpReady = 1'b0;
          stallLeft--;
        end else begin
          dumpReady = 1'b1;
        end
      end
      @(posedge clk);
      edges++;
      if (sawValid && dumpReady) begin
        words++;
        edges = 0;
        seen  = 1'b0;
      end
    end
    #1;
    dumpReady = 1'b0;
    checkOutput("dumpWords", words, 8);
  endtask

  initial begin
    int holdCnt;
    int runCnt;

    vecA[0] = '{1'b1, 32'h1111_0001, 1'b0, 1'b1, 1'b1, 3'd0};
    vecA[1] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 3'd1};
    vecA[2] = '{1'b1, 32'h1111_0002, 1'b0, 1'b1, 1'b1, 3'd1};
    vecA[3] = '{1'b1, 32'h1111_0003, 1'b1, 1'b1, 1'b1, 3'd2};
    for (int i = 0; i < 8; i++) vecB[i] = '{1'b1, 32'h2222_0000 + i, 1'b0, 1'b1, 1'b1, 3'(i)};
    vecB[8] = '{1'b1, 32'h2222_00FF, 1'b0, 1'b0, 1'b0, 3'd0};
    vecC[0] = '{1'b1, 32'h3333_0000, 1'b0, 1'b1, 1'b1, 3'd0};
    vecC[1] = '{1'b1, 32'h3333_0001, 1'b1, 1'b1, 1'b1, 3'd1};
    for (int i = 0; i < 8; i++) expMem[i] = 32'hC0DE_0000 + i;

    reset = 1'b1; memPreload = 1'b1; start = 1'b0; loadValid = 1'b0;
    loadData = '0; loadLast = 1'b0; ledBus = '0; dumpReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstCpuReset", cpuReset, 1'b1);
    checkOutput("rstMemOwn", memOwn, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstDumpValid", dumpValid, 1'b0);
    checkOutput("rstLoadReady", loadReady, 1'b0);
    checkOutput("rstRunCycles", runCycles, 32'd0);
    @(negedge clk);
    reset = 1'b0; memPreload = 1'b0;

    $display("[TB] scenario 1: three-word load, LED edge at run cycle 50");
    pulseStart();
    checkOutput("loadBusy", busy, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(vecA[i], "loadA");
    holdCnt = 0;
    while (cpuReset && holdCnt < 40) begin
      holdCnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("holdCycles", holdCnt, 10);
    checkOutput("runMemOwn", memOwn, 1'b0);
    checkOutput("runBusy", busy, 1'b1);
    checkOutput("runStartCount", runCycles, 32'd0);
    repeat (49) @(posedge clk);
    #1;
    checkOutput("runCpuReset49", cpuReset, 1'b0);
    checkOutput("runCycles49", runCycles, 32'd49);
    ledBus[0] = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("edgeCpuReset", cpuReset, 1'b1);
    checkOutput("edgeRunCycles", runCycles, 32'd50);
    checkOutput("edgeTimedOut", timedOut, 1'b0);
    checkOutput("edgeMemOwn", memOwn, 1'b1);
    dumpAll(-1, 0);
    checkOutput("finDone", done, 1'b1);
    checkOutput("finBusy", busy, 1'b0);
    checkOutput("finTimedOut", timedOut, 1'b0);
    checkOutput("finCpuReset", cpuReset, 1'b1);

    $display("[TB] scenario 2: full-depth load, LED high at entry, timeout, dump stall");
    pulseStart();
    checkOutput("restartDone", done, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(vecB[i], "loadB");
    waitRunEntry();
    runCnt = 1;
    for (int c = 0; c < 200 && !cpuReset; c++) begin
      @(posedge clk);
      #1;
      if (!cpuReset) runCnt++;
    end
    checkOutput("timeoutRunLen", runCnt, TIMEOUT_P);
    checkOutput("timeoutRunCycles", runCycles, 32'(TIMEOUT_P));
    checkOutput("timeoutFlag", timedOut, 1'b1);
    dumpAll(3, 5);
    checkOutput("toDone", done, 1'b1);
    checkOutput("toTimedOutHeld", timedOut, 1'b1);

    $display("[TB] scenario 3: reset in the middle of a dump, then a clean sequence");
    ledBus[0] = 1'b0;
    pulseStart();
    checkOutput("clearTimedOut", timedOut, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(vecC[i], "loadC");
    waitRunEntry();
    repeat (3) @(posedge clk);
    #1;
    ledBus[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midDumpValid", dumpValid, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncCpuReset", cpuReset, 1'b1);
    checkOutput("asyncMemOwn", memOwn, 1'b1);
    checkOutput("asyncDumpValid", dumpValid, 1'b0);
    checkOutput("asyncBusy", busy, 1'b0);
    checkOutput("asyncRunCycles", runCycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ledBus[0] = 1'b0;
    pulseStart();
    for (int i = 0; i < 2; i++) applyStimulus(vecC[i], "loadD");
    waitRunEntry();
    repeat (4) @(posedge clk);
    #1;
    ledBus[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("againRunCycles", runCycles, 32'd5);
    dumpAll(-1, 0);
    checkOutput("againDone", done, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
